// File: rtl/rv32i_lsu.sv
// Load/store unit for the rv32i core: one request at a time, registered memory
// controls, load extension, alignment/legality checking and a single response pulse.
module rv32i_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_load,
    input  logic                      req_store,
    input  logic [2:0]                req_funct3,
    input  logic [DATA_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd,
    output logic                      resp_valid,
    output logic                      resp_we,
    output logic [REG_ADDR_WIDTH-1:0] resp_rd,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      resp_misalign,
    output logic [DATA_WIDTH-1:0]     resp_fault_addr,
    output logic [DATA_WIDTH-1:0]     daddr,
    output logic [DATA_WIDTH-1:0]     ddout,
    input  logic [DATA_WIDTH-1:0]     ddin,
    output logic                      dwe0,
    output logic                      dwe1,
    output logic                      dwe2
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    function automatic logic op_legal(input logic ld, input logic st, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = ld ^ st;
            3'b100, 3'b101:         ok = ld & ~st;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic op_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = |a;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Store data is right-aligned; bytes above the access size are cleared.
    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [2:0] f3,
                                                         input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] d;
        d = w;
        case (f3[1:0])
            2'b00:   d = {{(DATA_WIDTH-8){1'b0}}, w[7:0]};
            2'b01:   d = {{(DATA_WIDTH-16){1'b0}}, w[15:0]};
            default: d = w;
        endcase
        return d;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                          input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = d;
        case (f3)
            3'b000:  r = {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
            3'b001:  r = {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
            3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
            3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    logic [1:0]                state_q, state_d;
    logic                      req_ready_q, req_ready_d;
    logic                      load_q, load_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0]     daddr_q, daddr_d;
    logic [DATA_WIDTH-1:0]     ddout_q, ddout_d;
    logic                      dwe0_q, dwe0_d;
    logic                      dwe1_q, dwe1_d;
    logic                      dwe2_q, dwe2_d;
    logic                      resp_valid_q, resp_valid_d;
    logic                      resp_we_q, resp_we_d;
    logic [REG_ADDR_WIDTH-1:0] resp_rd_q, resp_rd_d;
    logic [DATA_WIDTH-1:0]     resp_rdata_q, resp_rdata_d;
    logic                      resp_misalign_q, resp_misalign_d;
    logic [DATA_WIDTH-1:0]     resp_fault_addr_q, resp_fault_addr_d;
    logic                      legal_s;
    logic                      misalign_s;

    assign legal_s    = op_legal(req_load, req_store, req_funct3);
    assign misalign_s = op_misaligned(req_funct3, req_addr[1:0]);

    // Next-state and next-output computation for the request sequencer.
    always_comb begin
        state_d           = state_q;
        load_d            = load_q;
        funct3_d          = funct3_q;
        rd_d              = rd_q;
        daddr_d           = daddr_q;
        ddout_d           = ddout_q;
        dwe0_d            = 1'b0;
        dwe1_d            = 1'b0;
        dwe2_d            = 1'b0;
        resp_valid_d      = 1'b0;
        resp_we_d         = resp_we_q;
        resp_rd_d         = resp_rd_q;
        resp_rdata_d      = resp_rdata_q;
        resp_misalign_d   = resp_misalign_q;
        resp_fault_addr_d = resp_fault_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    load_d   = req_load;
                    funct3_d = req_funct3;
                    rd_d     = req_rd;
                    if (!legal_s || misalign_s) begin
                        // Rejected requests answer immediately and never touch memory.
                        state_d           = ST_RESP;
                        resp_valid_d      = 1'b1;
                        resp_we_d         = 1'b0;
                        resp_rd_d         = req_rd;
                        resp_rdata_d      = '0;
                        resp_misalign_d   = legal_s;
                        resp_fault_addr_d = legal_s ? req_addr : '0;
                    end else begin
                        state_d = ST_ISSUE;
                        daddr_d = req_addr;
                        if (req_store) begin
                            ddout_d = store_data(req_funct3, req_wdata);
                            dwe0_d  = (req_funct3[1:0] == 2'b00);
                            dwe1_d  = (req_funct3[1:0] == 2'b01);
                            dwe2_d  = (req_funct3[1:0] == 2'b10);
                        end else begin
                            ddout_d = ddout_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (load_q) begin
                    state_d = ST_READ;
                end else begin
                    state_d           = ST_RESP;
                    resp_valid_d      = 1'b1;
                    resp_we_d         = 1'b0;
                    resp_rd_d         = rd_q;
                    resp_rdata_d      = '0;
                    resp_misalign_d   = 1'b0;
                    resp_fault_addr_d = '0;
                end
            end
            ST_READ: begin
                state_d           = ST_RESP;
                resp_valid_d      = 1'b1;
                resp_we_d         = (rd_q != '0);
                resp_rd_d         = rd_q;
                resp_rdata_d      = load_extend(funct3_q, ddin);
                resp_misalign_d   = 1'b0;
                resp_fault_addr_d = '0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= ST_IDLE;
            req_ready_q       <= 1'b1;
            load_q            <= 1'b0;
            funct3_q          <= 3'b000;
            rd_q              <= '0;
            daddr_q           <= '0;
            ddout_q           <= '0;
            dwe0_q            <= 1'b0;
            dwe1_q            <= 1'b0;
            dwe2_q            <= 1'b0;
            resp_valid_q      <= 1'b0;
            resp_we_q         <= 1'b0;
            resp_rd_q         <= '0;
            resp_rdata_q      <= '0;
            resp_misalign_q   <= 1'b0;
            resp_fault_addr_q <= '0;
        end else begin
            state_q           <= state_d;
            req_ready_q       <= req_ready_d;
            load_q            <= load_d;
            funct3_q          <= funct3_d;
            rd_q              <= rd_d;
            daddr_q           <= daddr_d;
            ddout_q           <= ddout_d;
            dwe0_q            <= dwe0_d;
            dwe1_q            <= dwe1_d;
            dwe2_q            <= dwe2_d;
            resp_valid_q      <= resp_valid_d;
            resp_we_q         <= resp_we_d;
            resp_rd_q         <= resp_rd_d;
            resp_rdata_q      <= resp_rdata_d;
            resp_misalign_q   <= resp_misalign_d;
            resp_fault_addr_q <= resp_fault_addr_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_we         = resp_we_q;
    assign resp_rd         = resp_rd_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misalign   = resp_misalign_q;
    assign resp_fault_addr = resp_fault_addr_q;
    assign daddr           = daddr_q;
    assign ddout           = ddout_q;
    assign dwe0            = dwe0_q;
    assign dwe1            = dwe1_q;
    assign dwe2            = dwe2_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: directed vector table, randomized requests against
// a byte-array reference model, back-to-back handshake and mid-operation reset.
module tb_rv32i_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic [31:0] resp_fault_addr;
    logic [31:0] daddr;
    logic [31:0] ddout;
    logic [31:0] ddin;
    logic        dwe0;
    logic        dwe1;
    logic        dwe2;

    rv32i_lsu #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
        .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
        .resp_fault_addr(resp_fault_addr),
        .daddr(daddr), .ddout(ddout), .ddin(ddin),
        .dwe0(dwe0), .dwe1(dwe1), .dwe2(dwe2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory device (256 bytes, aliased on daddr[7:0]) and independent reference copy.
    logic [7:0] dmem [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] mem_a;
    assign mem_a = daddr[7:0];

    always @(posedge clk) begin
        if (dwe0) dmem[mem_a] <= ddout[7:0];
        if (dwe1) begin
            dmem[mem_a]        <= ddout[7:0];
            dmem[mem_a + 8'd1] <= ddout[15:8];
        end
        if (dwe2) begin
            dmem[mem_a]        <= ddout[7:0];
            dmem[mem_a + 8'd1] <= ddout[15:8];
            dmem[mem_a + 8'd2] <= ddout[23:16];
            dmem[mem_a + 8'd3] <= ddout[31:24];
        end
        ddin <= {dmem[mem_a + 8'd3], dmem[mem_a + 8'd2], dmem[mem_a + 8'd1], dmem[mem_a]};
    end

    typedef struct {
        bit        ld;
        bit        st;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [4:0]  rd;
        int        lat;
        bit [2:0]  dwe;
        bit [31:0] ddout;
        bit [31:0] rdata;
        bit        we;
        bit        mis;
        bit [31:0] fault;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_daddr = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic void ref_commit(bit [31:0] addr, int size, bit [31:0] wdata);
        for (int i = 0; i < size; i++) ref_mem[8'(addr + 32'(i))] = wdata[8*i +: 8];
    endfunction

    // Reference model: legality, alignment, size and sign rules in plain arithmetic.
    function automatic vec_t model(bit ld, bit st, bit [2:0] f3, bit [31:0] addr,
                                   bit [31:0] wdata, bit [4:0] rd);
        vec_t v;
        int size;
        bit legal;
        bit [63:0] mask;
        bit [63:0] val;
        v = '{ld, st, f3, addr, wdata, rd, 1, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        size = 1 << f3[1:0];
        if (ld && !st)      legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else if (st && !ld) legal = (f3 <= 3'd2);
        else                legal = 1'b0;
        if (!legal) return v;
        if ((addr % size) != 0) begin
            v.mis   = 1'b1;
            v.fault = addr;
            return v;
        end
        mask = (64'd1 << (8 * size)) - 64'd1;
        if (st) begin
            v.lat   = 2;
            v.dwe   = (size == 1) ? 3'b001 : (size == 2) ? 3'b010 : 3'b100;
            v.ddout = 32'({32'h0, wdata} & mask);
            ref_commit(addr, size, wdata);
        end else begin
            v.lat = 3;
            val = 64'h0;
            for (int i = 0; i < size; i++) val = val | (64'(ref_mem[8'(addr + 32'(i))]) << (8 * i));
            if (!f3[2] && val[8*size-1]) val = val | ~mask;
            v.rdata = val[31:0];
            v.we    = (rd != 5'd0);
        end
        return v;
    endfunction

    // One isolated request with cycle-exact checks of memory controls and response.
    task automatic run_req(input vec_t v, input string nm);
        @(negedge clk);
        chk({nm, "_ready_idle"}, 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_load = v.ld; req_store = v.st; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_load   = 1'($urandom_range(0, 1));
        req_store  = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rd     = 5'($urandom_range(0, 31));
        for (int k = 1; k <= v.lat; k++) begin
            if (k > 1) @(negedge clk);
            chk({nm, "_ready_busy"}, 32'(req_ready), 32'h0);
            chk({nm, "_dwe"}, 32'({dwe2, dwe1, dwe0}), (k == 1) ? 32'(v.dwe) : 32'h0);
            chk({nm, "_resp_valid"}, 32'(resp_valid), (k == v.lat) ? 32'h1 : 32'h0);
            if (k == 1) chk({nm, "_daddr"}, daddr, (v.lat > 1) ? v.addr : last_daddr);
            if (k == 1 && v.dwe != 3'b000) chk({nm, "_ddout"}, ddout, v.ddout);
        end
        chk({nm, "_we"}, 32'(resp_we), 32'(v.we));
        chk({nm, "_misalign"}, 32'(resp_misalign), 32'(v.mis));
        chk({nm, "_fault"}, resp_fault_addr, v.fault);
        if (v.lat == 3) begin
            chk({nm, "_rdata"}, resp_rdata, v.rdata);
            chk({nm, "_rd"}, 32'(resp_rd), 32'(v.rd));
        end
        if (v.lat > 1) last_daddr = v.addr;
        @(negedge clk);
        chk({nm, "_pulse_end"}, 32'(resp_valid), 32'h0);
        chk({nm, "_ready_after"}, 32'(req_ready), 32'h1);
        chk({nm, "_we_hold"}, 32'(resp_we), 32'(v.we));
    endtask

    task automatic back_to_back();
        vec_t q[$];
        int   due[$];
        vec_t e;
        int   issued;
        int   got;
        int   n_ops;
        bit   acc;
        n_ops = 6; issued = 0; got = 0;
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'hC010; req_wdata = $urandom; req_rd = 5'd0;
        for (int c = 0; c < 60 && got < n_ops; c++) begin
            chk("b2b_ready", 32'(req_ready), (q.size() == 0) ? 32'h1 : 32'h0);
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("b2b_spurious_resp", 32'h1, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("b2b_resp_cycle", 32'(c), 32'(due.pop_front()));
                    chk("b2b_we", 32'(resp_we), 32'(e.we));
                    if (e.lat == 3) chk("b2b_rdata", resp_rdata, e.rdata);
                    got++;
                end
            end
            acc = req_ready && req_valid;
            if (acc) begin
                e = model(req_load, req_store, req_funct3, req_addr, req_wdata, req_rd);
                q.push_back(e);
                due.push_back(c + e.lat);
                issued++;
            end
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                if (issued == n_ops) begin
                    req_valid = 1'b0;
                end else if (issued % 2 == 0) begin
                    req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'd0;
                    req_addr = 32'hC010 + 32'(issued / 2); req_wdata = $urandom; req_rd = 5'd0;
                end else begin
                    req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'd2;
                    req_addr = 32'hC010; req_rd = 5'(issued);
                end
            end
        end
        req_valid = 1'b0;
        chk("b2b_responses", 32'(got), 32'(n_ops));
        chk("b2b_issued", 32'(issued), 32'(n_ops));
        last_daddr = 32'hC010;
    endtask

    vec_t tbl[21];
    vec_t rv;

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 8'(i);
            ref_mem[i] = 8'(i);
        end
        rst = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_dwe", 32'({dwe2, dwe1, dwe0}), 32'h0);
        chk("rst_daddr", daddr, 32'h0);
        chk("rst_ddout", ddout, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_misalign_fault", {resp_fault_addr[30:0], resp_misalign}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h1);

        //          ld    st    f3    addr          wdata         rd  lat dwe     ddout         rdata         we    mis   fault
        tbl[0]  = '{1'b0, 1'b1, 3'd2, 32'hC000,     32'hDEADBEEF, 5'd0, 2, 3'b100, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 32'hC000,     32'h0,        5'd5, 3, 3'b000, 32'h0,        32'hFFFFFFEF, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 3'd4, 32'hC000,     32'h0,        5'd5, 3, 3'b000, 32'h0,        32'h000000EF, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 3'd1, 32'hC002,     32'h0,        5'd6, 3, 3'b000, 32'h0,        32'hFFFFDEAD, 1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 3'd2, 32'hC000,     32'h0,        5'd7, 3, 3'b000, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 3'd1, 32'hC001,     32'h00001234, 5'd0, 1, 3'b000, 32'h0,        32'h0,        1'b0, 1'b1, 32'hC001};
        tbl[6]  = '{1'b1, 1'b0, 3'd2, 32'hC002,     32'h0,        5'd4, 1, 3'b000, 32'h0,        32'h0,        1'b0, 1'b1, 32'hC002};
        tbl[7]  = '{1'b1, 1'b0, 3'd2, 32'hC000,     32'h0,        5'd0, 3, 3'b000, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 3'd3, 32'hC000,     32'h0,        5'd8, 1, 3'b000, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 3'd5, 32'hC002,     32'h0,        5'd9, 3, 3'b000, 32'h0,        32'h0000DEAD, 1'b1, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 3'd0, 32'hC001,     32'h12345677, 5'd0, 2, 3'b001, 32'h00000077, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 3'd2, 32'hC000,     32'h0,        5'd10, 3, 3'b000, 32'h0,       32'hDEAD77EF, 1'b1, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 1'b1, 3'd1, 32'hC002,     32'hAABB8001, 5'd0, 2, 3'b010, 32'h00008001, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 3'd2, 32'hC000,     32'h0,        5'd11, 3, 3'b000, 32'h0,       32'h800177EF, 1'b1, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 3'd1, 32'hC002,     32'h0,        5'd12, 3, 3'b000, 32'h0,       32'hFFFF8001, 1'b1, 1'b0, 32'h0};
        tbl[15] = '{1'b1, 1'b1, 3'd2, 32'hC000,     32'h0,        5'd13, 1, 3'b000, 32'h0,       32'h0,        1'b0, 1'b0, 32'h0};
        tbl[16] = '{1'b0, 1'b0, 3'd0, 32'hC000,     32'h0,        5'd14, 1, 3'b000, 32'h0,       32'h0,        1'b0, 1'b0, 32'h0};
        tbl[17] = '{1'b0, 1'b1, 3'd4, 32'hC000,     32'h0,        5'd0, 1, 3'b000, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        tbl[18] = '{1'b1, 1'b0, 3'd2, 32'hFFFFFFFC, 32'h0,        5'd3, 3, 3'b000, 32'h0,        32'hFFFEFDFC, 1'b1, 1'b0, 32'h0};
        tbl[19] = '{1'b1, 1'b0, 3'd0, 32'hC003,     32'h0,        5'd1, 3, 3'b000, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0, 32'h0};
        tbl[20] = '{1'b1, 1'b0, 3'd5, 32'hC001,     32'h0,        5'd2, 1, 3'b000, 32'h0,        32'h0,        1'b0, 1'b1, 32'hC001};

        for (int i = 0; i < 21; i++) begin
            run_req(tbl[i], $sformatf("vec%0d", i));
            if (tbl[i].lat == 2) ref_commit(tbl[i].addr, 1 << tbl[i].f3[1:0], tbl[i].wdata);
        end

        // Randomized requests against the reference model
        for (int i = 0; i < 120; i++) begin
            int  r;
            bit  ld;
            bit  st;
            r = int'($urandom_range(0, 9));
            ld = (r == 0) || (r >= 2 && r <= 5);
            st = (r == 0) || (r >= 6);
            rv = model(ld, st, 3'($urandom_range(0, 7)), 32'hC000 + 32'($urandom_range(0, 15)),
                       $urandom, 5'($urandom_range(0, 31)));
            run_req(rv, $sformatf("rnd%0d", i));
        end

        back_to_back();

        // Reset during the ISSUE cycle of a word store
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'hC020; req_wdata = 32'hA5A55A5A; req_rd = 5'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_rst_dwe2_before", 32'(dwe2), 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_dwe2_dropped", 32'(dwe2), 32'h0);
        chk("mid_rst_no_resp", 32'(resp_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        last_daddr = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) chk("mid_rst_ready", 32'(req_ready), 32'h1);
            chk("mid_rst_no_late_resp", 32'(resp_valid), 32'h0);
        end
        rv = model(1'b1, 1'b0, 3'd2, 32'hC020, 32'h0, 5'd17);
        run_req(rv, "mid_rst_mem_unchanged");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
